alu_pipe: RTL

//   Registered, parametrised successor to the 8-bit combinational ALU. Accepts one op per

---
 rtl/alu_pipe_pkg.sv | 25 ++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for alu_pipe, alu_core and their bench.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // flags bus is {N,V,C,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath for the single-cycle opcodes (ADD..SHR); op 111 yields zero result and flags.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [SHW-1:0]   amt;
    logic             c;
    logic             v;

    assign amt  = b[SHW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // One extra bit on the exit side of each shifter catches the last bit shifted out.
    assign shl_w = {1'b0, a} << amt;
    assign shr_w = {a, 1'b0} >> amt;

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                c      = ~diff[WIDTH];
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_w[WIDTH-1:0];
                c      = shl_w[WIDTH];
            end
            OP_SHR: begin
                result = shr_w[WIDTH:1];
                c      = shr_w[0];
            end
            default: ;
        endcase
        flags = (op == OP_MUL) ? 4'b0000 : {result[WIDTH-1], v, c, (result == '0)};
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered valid/ready ALU with an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to enable op 111 as MUL; otherwise op 111 returns err=1 in one cycle.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [2:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [SHW-1:0]   cnt;
    logic             accept;
    logic             consume;
    logic             is_mul;
    logic             mul_start;
    logic             mul_last;
    logic             single_load;
    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flags;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (num1),
        .b      (num2),
        .op     (oper),
        .result (core_res),
        .flags  (core_flags)
    );

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    assign is_mul  = (oper == OP_MUL);

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign mul_start = accept & is_mul;
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

    // One multiplier bit per cycle, LSB first; the full product is kept for the carry flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (mul_start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, num1};
            mplier <= num2;
        end else if (state == ST_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign mul_res   = acc_nxt[WIDTH-1:0];
    assign mul_flags = {mul_res[WIDTH-1], 1'b0, |acc_nxt[2*WIDTH-1:WIDTH], (mul_res == '0)};
`else
    assign mul_start = 1'b0;
    assign mul_res   = '0;
    assign mul_flags = '0;
`endif

    assign single_load = accept & ~mul_start;
    assign mul_last    = (state == ST_MUL) && (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_MUL) ? cnt + SHW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_last)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    end

    // A load on the same edge as a consume simply reloads; otherwise a consume drops out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else if (single_load) begin
            out_valid <= 1'b1;
            result    <= core_res;
            flags     <= core_flags;
            err       <= is_mul;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            result    <= mul_res;
            flags     <= mul_flags;
            err       <= 1'b0;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule
